slice_lane_collector: RTL and testbench

- Downstream stage of the Controller/Datapath pair. Captures the 64 processed 25-bit slices, one per completed line.
- Transposes the slices into 25 lanes of 64 bits (lane m bit n = slice n bit m), matching the state layout used for input.
- Streams the lanes out over a valid/ready handshake to the output writer or the next round.
- Double role as a buffer: it back-pressures the Datapath while draining.

---
 rtl/slice_lane_collector_pkg.sv | 21 ++
 rtl/slice_lane_collector_if.sv | 24 ++
 rtl/slice_lane_collector_lane_store.sv | 39 +++
 rtl/slice_lane_collector.sv | 135 +++++++++++++
 tb/tb_slice_lane_collector.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/slice_lane_collector_pkg.sv
// Shared constants and types for the slice/lane collector and its neighbours.
// A slice is one bit from each of the 25 lanes. A state holds 64 slices.
package slice_lane_collector_pkg;

    localparam int SLICE_W   = 25;
    localparam int DEPTH     = 64;
    localparam int NUM_LANES = 25;
    localparam int CNT_W     = 6;
    localparam int IDX_W     = 5;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    // Keccak lane numbering: lane (x, y) lives at index x + 5*y.
    function automatic logic [IDX_W-1:0] idx(input int unsigned x, input int unsigned y);
        return IDX_W'(x + 5 * y);
    endfunction

endpackage

// File: rtl/slice_lane_collector_if.sv
// Lane output stream: the collector presents one 64-bit lane per handshake.
interface slice_lane_collector_if;
    import slice_lane_collector_pkg::*;

    logic             lane_valid;
    logic             lane_ready;
    logic [IDX_W-1:0] lane_idx;
    logic [DEPTH-1:0] lane_out;

    modport master (
        output lane_valid,
        output lane_idx,
        output lane_out,
        input  lane_ready
    );

    modport slave (
        input  lane_valid,
        input  lane_idx,
        input  lane_out,
        output lane_ready
    );

endinterface

// File: rtl/slice_lane_collector_lane_store.sv
// 25 x 64 transpose store: slices are written as columns and lanes are read as rows.
// The contents are not reset, because every FILL overwrites all 64 columns.
module slice_lane_collector_lane_store
    import slice_lane_collector_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic [CNT_W-1:0]   wr_col,
    input  logic [SLICE_W-1:0] wr_data,
    input  logic [IDX_W-1:0]   rd_row,
    output logic [DEPTH-1:0]   rd_data
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(SLICE_W - 1);

    logic [DEPTH-1:0] lane_q [SLICE_W];
    logic [DEPTH-1:0] lane_d [SLICE_W];

    always_comb begin
        lane_d = lane_q;
        if (wr_en) begin
            for (int unsigned m = 0; m < SLICE_W; m++) begin
                lane_d[m][wr_col] = wr_data[m];
            end
        end
    end

    always_ff @(posedge clk) begin
        lane_q <= lane_d;
    end

    always_comb begin
        rd_data = '0;
        if (rd_row <= LAST_ROW) begin
            rd_data = lane_q[rd_row];
        end
    end

endmodule

// File: rtl/slice_lane_collector.sv
// Collects 64 slices into the transpose store, then streams out 25 lanes.
// While it drains, slice_ready is held low so that the Datapath stalls.
module slice_lane_collector
    import slice_lane_collector_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        slice_valid,
    input  logic [SLICE_W-1:0]          slice_in,
    output logic                        slice_ready,
    output logic [CNT_W-1:0]            slice_cnt,
    slice_lane_collector_if.master      lane,
    output logic                        busy,
    output logic                        done
);

    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_LANE  = IDX_W'(NUM_LANES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
    logic [IDX_W-1:0] lane_idx_q, lane_idx_d;
    logic             lane_valid_q, lane_valid_d;
    logic [DEPTH-1:0] lane_out_q, lane_out_d;
    logic             done_q, done_d;

    logic             accept;
    logic             handshake;
    logic             last_slice;
    logic             last_lane;
    logic [IDX_W-1:0] rd_row;
    logic [DEPTH-1:0] rd_data;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FILL;
            slice_cnt_q  <= '0;
            lane_idx_q   <= '0;
            lane_valid_q <= 1'b0;
            lane_out_q   <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            slice_cnt_q  <= slice_cnt_d;
            lane_idx_q   <= lane_idx_d;
            lane_valid_q <= lane_valid_d;
            lane_out_q   <= lane_out_d;
            done_q       <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = FILL;
        end else begin
            unique case (state_q)
                FILL:    if (accept && last_slice)   state_d = DRAIN;
                DRAIN:   if (handshake && last_lane) state_d = FILL;
                default: state_d = FILL;
            endcase
        end
    end

    // Output and handshake decode
    always_comb begin
        slice_ready = (state_q == FILL);
        busy        = (state_q == DRAIN);
        accept      = slice_ready & slice_valid & ~clear;
        handshake   = lane_valid_q & lane.lane_ready & ~clear;
        last_slice  = (slice_cnt_q == LAST_SLICE);
        last_lane   = (lane_idx_q == LAST_LANE);
    end

    // Prefetch the row that will be presented after the current handshake.
    always_comb begin
        rd_row = '0;
        if (state_q == DRAIN && !last_lane) begin
            rd_row = lane_idx_q + 1'b1;
        end
    end

    always_comb begin
        slice_cnt_d  = slice_cnt_q;
        lane_idx_d   = lane_idx_q;
        lane_valid_d = lane_valid_q;
        lane_out_d   = lane_out_q;
        done_d       = 1'b0;
        if (clear) begin
            slice_cnt_d  = '0;
            lane_idx_d   = '0;
            lane_valid_d = 1'b0;
        end else begin
            if (accept) begin
                slice_cnt_d = slice_cnt_q + 1'b1;
                if (last_slice) begin
                    // Column 63 is written on this same edge, so lane 0's top bit
                    // comes straight from the incoming slice.
                    lane_valid_d = 1'b1;
                    lane_idx_d   = '0;
                    lane_out_d   = {slice_in[0], rd_data[DEPTH-2:0]};
                end
            end
            if (handshake) begin
                if (last_lane) begin
                    lane_valid_d = 1'b0;
                    lane_idx_d   = '0;
                    done_d       = 1'b1;
                end else begin
                    lane_idx_d   = lane_idx_q + 1'b1;
                    lane_out_d   = rd_data;
                end
            end
        end
    end

    slice_lane_collector_lane_store u_lane_store (
        .clk     (clk),
        .wr_en   (accept),
        .wr_col  (slice_cnt_q),
        .wr_data (slice_in),
        .rd_row  (rd_row),
        .rd_data (rd_data)
    );

    assign slice_cnt       = slice_cnt_q;
    assign lane.lane_valid = lane_valid_q;
    assign lane.lane_idx   = lane_idx_q;
    assign lane.lane_out   = lane_out_q;
    assign done            = done_q;

endmodule

// File: tb/tb_slice_lane_collector.sv
// Directed and randomized bench for slice_lane_collector.
// Expected lanes are computed by transposing the slices that were sent.
module tb_slice_lane_collector;
    import slice_lane_collector_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear;
    logic               slice_valid;
    logic [SLICE_W-1:0] slice_in;
    logic               slice_ready;
    logic [CNT_W-1:0]   slice_cnt;
    logic               busy;
    logic               done;

    slice_lane_collector_if lane_bus ();

    slice_lane_collector dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .slice_valid (slice_valid),
        .slice_in    (slice_in),
        .slice_ready (slice_ready),
        .slice_cnt   (slice_cnt),
        .lane        (lane_bus),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [SLICE_W-1:0] sl [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lane m collects bit m of every slice: bit n of the lane is taken from slice n.
    function automatic logic [DEPTH-1:0] exp_lane(input int m);
        logic [DEPTH-1:0] r;
        for (int n = 0; n < DEPTH; n++) r[n] = sl[n][m];
        return r;
    endfunction

    task automatic randomize_slices();
        for (int n = 0; n < DEPTH; n++) sl[n] = SLICE_W'($urandom);
    endtask

    // gap_mode: 0 = back-to-back, 1 = every other cycle, 2 = random gaps
    task automatic fill(input int gap_mode, input int stop_at);
        int n = 0;
        int cyc = 0;
        bit v;
        while (n < stop_at) begin
            chk("fill_ready", 64'(slice_ready), 64'd1);
            chk("fill_cnt", 64'(slice_cnt), 64'(n));
            chk("fill_busy", 64'(busy), 64'd0);
            chk("fill_lane_valid", 64'(lane_bus.lane_valid), 64'd0);
            if (cyc > 0) chk("fill_done", 64'(done), 64'd0);
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            slice_valid = v;
            slice_in    = v ? sl[n] : SLICE_W'($urandom);
            lane_bus.lane_ready = 1'($urandom_range(0, 1));
            if (v) n++;
            @(negedge clk);
            cyc++;
            if (cyc > 1000) begin
                chk("fill_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        slice_valid = 1'b0;
        lane_bus.lane_ready = 1'b0;
    endtask

    // ready_mode: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
    task automatic drain(input int ready_mode, input int stop_k, input bit hold);
        int k = 0;
        int cyc = 0;
        bit r;
        while (k < stop_k) begin
            chk("drain_busy", 64'(busy), 64'd1);
            chk("drain_valid", 64'(lane_bus.lane_valid), 64'd1);
            chk("drain_slice_ready", 64'(slice_ready), 64'd0);
            chk("drain_cnt", 64'(slice_cnt), 64'd0);
            chk("drain_done", 64'(done), 64'd0);
            chk("drain_idx", 64'(lane_bus.lane_idx), 64'(k));
            chk("drain_lane", lane_bus.lane_out, exp_lane(k));
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            lane_bus.lane_ready = r;
            if (hold) begin
                slice_valid = 1'b1;
                slice_in    = 25'h0AAAAAA;
            end else begin
                slice_valid = 1'($urandom_range(0, 1));
                slice_in    = SLICE_W'($urandom);
            end
            if (r) k++;
            @(negedge clk);
            cyc++;
            if (cyc > 400) begin
                chk("drain_timeout", 64'(cyc), 64'd0);
                break;
            end
        end
        lane_bus.lane_ready = 1'b0;
        if (!hold) slice_valid = 1'b0;
        if (stop_k == NUM_LANES) begin
            chk("drain_handshakes", 64'(k), 64'd25);
            chk("end_done", 64'(done), 64'd1);
            chk("end_valid", 64'(lane_bus.lane_valid), 64'd0);
            chk("end_busy", 64'(busy), 64'd0);
            chk("end_slice_ready", 64'(slice_ready), 64'd1);
            chk("end_idx", 64'(lane_bus.lane_idx), 64'd0);
            chk("end_cnt", 64'(slice_cnt), 64'd0);
            if (ready_mode == 0) chk("drain_consecutive", 64'(cyc), 64'd25);
        end else begin
            chk("partial_idx", 64'(lane_bus.lane_idx), 64'(k));
            chk("partial_valid", 64'(lane_bus.lane_valid), 64'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_slice_ready"}, 64'(slice_ready), 64'd1);
        chk({tag, "_cnt"}, 64'(slice_cnt), 64'd0);
        chk({tag, "_valid"}, 64'(lane_bus.lane_valid), 64'd0);
        chk({tag, "_idx"}, 64'(lane_bus.lane_idx), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        clear = 1'b0;
        slice_valid = 1'b0;
        slice_in = '0;
        lane_bus.lane_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        chk("reset_lane_out", lane_bus.lane_out, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Identity pattern
        for (int n = 0; n < DEPTH; n++) sl[n] = 25'h1 << (n % 25);
        fill(0, 64);
        chk("identity_lane0", lane_bus.lane_out, 64'h0004_0000_0200_0001);
        drain(0, 25, 1'b0);

        // Back-pressure with all ones
        for (int n = 0; n < DEPTH; n++) sl[n] = 25'h1FFFFFF;
        fill(2, 64);
        drain(1, 25, 1'b0);

        // Producer holds a slice during DRAIN; it must land as column 0 of the next state
        randomize_slices();
        fill(0, 64);
        drain(2, 25, 1'b1);
        randomize_slices();
        sl[0] = 25'h0AAAAAA;
        fill(0, 64);
        drain(0, 25, 1'b0);

        // Input gaps every other cycle
        randomize_slices();
        fill(1, 64);
        drain(2, 25, 1'b0);

        // clear mid-FILL at slice_cnt = 40
        randomize_slices();
        fill(0, 40);
        chk("pre_clear_cnt", 64'(slice_cnt), 64'd40);
        clear = 1'b1;
        slice_valid = 1'b1;
        slice_in = SLICE_W'($urandom);
        @(negedge clk);
        clear = 1'b0;
        slice_valid = 1'b0;
        check_idle("clear_fill");

        // clear mid-DRAIN at lane_idx = 10
        randomize_slices();
        fill(0, 64);
        drain(0, 10, 1'b0);
        clear = 1'b1;
        lane_bus.lane_ready = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        lane_bus.lane_ready = 1'b0;
        check_idle("clear_drain");
        @(negedge clk);
        chk("clear_no_done", 64'(done), 64'd0);

        randomize_slices();
        fill(2, 64);
        drain(2, 25, 1'b0);

        // Reset during DRAIN abandons the state without a done pulse
        randomize_slices();
        fill(0, 64);
        drain(1, 5, 1'b0);
        rst = 1'b0;
        #1;
        check_idle("async_reset");
        chk("async_reset_lane_out", lane_bus.lane_out, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        randomize_slices();
        fill(0, 64);
        drain(0, 25, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
